booth_multiplier_seq: RTL

//  Parametrised iterative Booth multiplier; successor to the fixed 4-bit radix-2 unit.

---
 rtl/booth_multiplier_seq_if.sv | 16 +
 rtl/booth_multiplier_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq_if.sv
// Start/busy/valid handshake bundle for booth_multiplier_seq.
// Requesters drive start/tc/x/y; the multiplier returns busy/valid/z.
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               tc;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               busy;
    logic               valid;
    logic [2*WIDTH-1:0] z;

    modport master (output start, tc, x, y, input busy, valid, z);
    modport slave  (input start, tc, x, y, output busy, valid, z);
endinterface

// File: rtl/booth_multiplier_seq.sv
// Iterative Booth multiplier, signed or unsigned per operation, full 2*WIDTH product.
// Radix-2 by default; define BOOTH_RADIX4_EN for radix-4 modified Booth (WIDTH must be even).
module booth_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_multiplier_seq_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
    localparam int R  = 2;
    localparam int E  = WIDTH + 2;
    localparam int AW = E + 1;
    if (WIDTH % 2 != 0) begin : g_width_chk
        $error("booth_multiplier_seq: radix-4 build needs an even WIDTH");
    end
`else
    localparam int R  = 1;
    localparam int E  = WIDTH + 1;
    localparam int AW = E;
`endif
    localparam int N  = E / R;
    localparam int CW = $clog2(N + 1);
    localparam int SW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [AW-1:0]      a_q;
    logic [E-1:0]       q_q;
    logic [E-1:0]       m_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               valid_q;
    logic [2*WIDTH-1:0] z_q;

    logic [SW-1:0]      m_ext;
    logic [SW-1:0]      addend;
    logic [SW-1:0]      sum;
    logic [AW-1:0]      a_d;
    logic [E-1:0]       q_d;
    logic               qm1_d;
    logic [E-1:0]       x_ext;
    logic [E-1:0]       y_ext;

    // The extra high bit(s) make unsigned operands look positive to the recoder.
    assign x_ext = {{(E-WIDTH){bus.tc & bus.x[WIDTH-1]}}, bus.x};
    assign y_ext = {{(E-WIDTH){bus.tc & bus.y[WIDTH-1]}}, bus.y};
    assign m_ext = {{(SW-E){m_q[E-1]}}, m_q};

    always_comb begin
        addend = '0;
`ifdef BOOTH_RADIX4_EN
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum   = {a_q[AW-1], a_q} + addend;
        a_d   = {sum[SW-1], sum[SW-1:2]};
        q_d   = {sum[1:0], q_q[E-1:2]};
        qm1_d = q_q[1];
`else
        case ({q_q[0], qm1_q})
            2'b10:   addend = -m_ext;
            2'b01:   addend = m_ext;
            default: addend = '0;
        endcase
        // Sum carries one guard bit so the shift sees the true sign.
        sum   = {a_q[AW-1], a_q} + addend;
        a_d   = sum[SW-1:1];
        q_d   = {sum[0], q_q[E-1:1]};
        qm1_d = q_q[0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            z_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= '0;
                        q_q     <= y_ext;
                        m_q     <= x_ext;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CW'(N);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        z_q     <= (2*WIDTH)'({a_d, q_d});
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.z     = z_q;
endmodule
